// File: rtl/tour_swap_sweeper_pkg.sv
// Shared types for the tour swap sweeper: widths, coordinate record, FSM states.
// No ports; imported by the sweeper, its checker interface and the bench.
package tsp_pkg;

  localparam int COORD_W = 8;
  localparam int DIST_W  = 19;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_APPLY,
    S_NEXT,
    S_FIN
  } state_t;

endpackage

// File: rtl/tour_swap_sweeper_if.sv
// Sweeper <-> adjacent-swap checker bus: checker reset, 4-city window, result.
// master = sweeper (drives rst/window), slave = checker (drives res/complete/diff).
interface tour_swap_sweeper_if;
  import tsp_pkg::*;

  logic               chk_rst;
  logic [COORD_W-1:0] chk_x1, chk_y1;
  logic [COORD_W-1:0] chk_x2, chk_y2;
  logic [COORD_W-1:0] chk_x3, chk_y3;
  logic [COORD_W-1:0] chk_x4, chk_y4;
  logic               chk_res;
  logic               chk_complete;
  logic [DIST_W-1:0]  chk_difference;

  modport master (
    output chk_rst,
    output chk_x1, chk_y1, chk_x2, chk_y2,
    output chk_x3, chk_y3, chk_x4, chk_y4,
    input  chk_res, chk_complete, chk_difference
  );

  modport slave (
    input  chk_rst,
    input  chk_x1, chk_y1, chk_x2, chk_y2,
    input  chk_x3, chk_y3, chk_x4, chk_y4,
    output chk_res, chk_complete, chk_difference
  );

endinterface

// File: rtl/tour_swap_sweeper.sv
// Adjacent-swap tour sweeper: coord RAM, tour, 4-city window feed to checker.
// Ports: cw_* coord write, start/busy/done/err, results, rd_pos/rd_city, chk bus.
module tour_swap_sweeper #(
  parameter int N_CITY   = 16,
  parameter int IDX_W    = 4,
  parameter int COORD_W  = 8,
  parameter int DIST_W   = 19,
  parameter int GAIN_W   = 32,
  parameter int MAX_PASS = 8,
  parameter int TIMEOUT  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cw_en,
  input  logic [IDX_W-1:0]   cw_idx,
  input  logic [COORD_W-1:0] cw_x,
  input  logic [COORD_W-1:0] cw_y,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [GAIN_W-1:0]  total_gain,
  output logic [15:0]        swap_count,
  output logic [7:0]         pass_count,
  input  logic [IDX_W-1:0]   rd_pos,
  output logic [IDX_W-1:0]   rd_city,
  tour_swap_sweeper_if.master chk
);
  import tsp_pkg::*;

  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int LAST = (N_CITY >= 4) ? N_CITY - 4 : 0;

  coord_t             coord [N_CITY];
  logic [IDX_W-1:0]   tour  [N_CITY];
  state_t             state;
  logic [IDX_W-1:0]   pos;
  logic               pass_swapped;
  logic [TW-1:0]      tcnt;
  logic               res_q;
  logic [DIST_W-1:0]  diff_q;

  logic [IDX_W-1:0]   p1, p2, p3;
  coord_t             w0, w1, w2, w3;

  assign p1 = pos + IDX_W'(1);
  assign p2 = pos + IDX_W'(2);
  assign p3 = pos + IDX_W'(3);

  assign w0 = coord[tour[pos]];
  assign w1 = coord[tour[p1]];
  assign w2 = coord[tour[p2]];
  assign w3 = coord[tour[p3]];

  assign rd_city = tour[rd_pos];

  // Coordinate RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (cw_en && state == S_IDLE) begin
      coord[cw_idx] <= '{x: cw_x, y: cw_y};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      total_gain   <= '0;
      swap_count   <= '0;
      pass_count   <= '0;
      pos          <= '0;
      pass_swapped <= 1'b0;
      tcnt         <= '0;
      res_q        <= 1'b0;
      diff_q       <= '0;
      chk.chk_rst  <= 1'b1;
      chk.chk_x1   <= '0;
      chk.chk_y1   <= '0;
      chk.chk_x2   <= '0;
      chk.chk_y2   <= '0;
      chk.chk_x3   <= '0;
      chk.chk_y3   <= '0;
      chk.chk_x4   <= '0;
      chk.chk_y4   <= '0;
      for (int p = 0; p < N_CITY; p++) begin
        tour[p] <= IDX_W'(p);
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            total_gain   <= '0;
            swap_count   <= '0;
            err          <= 1'b0;
            pass_count   <= 8'd1;
            pos          <= '0;
            pass_swapped <= 1'b0;
            busy         <= 1'b1;
            state <= (N_CITY < 4) ? S_FIN : S_LOAD;
          end
        end
        S_LOAD: begin
          chk.chk_x1  <= w0.x;
          chk.chk_y1  <= w0.y;
          chk.chk_x2  <= w1.x;
          chk.chk_y2  <= w1.y;
          chk.chk_x3  <= w2.x;
          chk.chk_y3  <= w2.y;
          chk.chk_x4  <= w3.x;
          chk.chk_y4  <= w3.y;
          chk.chk_rst <= 1'b0;
          tcnt        <= '0;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          // Capture the result so APPLY does not depend on the
          // checker holding it once its reset is reasserted.
          if (chk.chk_complete) begin
            res_q       <= chk.chk_res;
            diff_q      <= chk.chk_difference;
            chk.chk_rst <= 1'b1;
            state       <= S_APPLY;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            err         <= 1'b1;
            chk.chk_rst <= 1'b1;
            state       <= S_FIN;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_APPLY: begin
          if (res_q) begin
            tour[p1]     <= tour[p2];
            tour[p2]     <= tour[p1];
            total_gain   <= total_gain + GAIN_W'(diff_q);
            pass_swapped <= 1'b1;
            if (swap_count != 16'hFFFF) begin
              swap_count <= swap_count + 16'd1;
            end
          end
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (pos < IDX_W'(LAST)) begin
            pos   <= pos + IDX_W'(1);
            state <= S_LOAD;
          end else if (pass_swapped &&
                       pass_count < 8'(MAX_PASS)) begin
            pos          <= '0;
            pass_swapped <= 1'b0;
            pass_count   <= pass_count + 8'd1;
            state        <= S_LOAD;
          end else begin
            state <= S_FIN;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
